// File: rtl/multi_stopwatch.sv
`default_nettype none
// multi_stopwatch: debounced start/stop, lap and clear buttons driving a DIGITS-wide BCD
// stopwatch with registered active-low seven-segment outputs.  Rev 1.0
module multi_stopwatch #(
   parameter int DIGITS     = 4,
   parameter int TICK_DIV   = 1_000_000,
   parameter int DEB_CYCLES = 100_000
) (
   input  logic                clk100_i,
   input  logic                rstn_i,
   input  logic                start_stop_i,
   input  logic                lap_i,
   input  logic                clear_i,
   output logic [7*DIGITS-1:0] hex_o,
   output logic                running_o,
   output logic                lap_o,
   output logic                overflow_o
);

   localparam int C_PW = $clog2(TICK_DIV);
   localparam int C_DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int C_BW = 4 * DIGITS;
   localparam logic [C_PW-1:0] C_TICK_LAST = C_PW'(TICK_DIV - 1);
   localparam logic [C_DW-1:0] C_DEB_LAST  = C_DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LAP   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [2:0]          w_raw;
   logic [2:0]          r_sync1;
   logic [2:0]          r_sync2;
   logic [2:0]          r_level;
   logic [2:0]          r_level_d;
   logic [C_DW-1:0]     r_deb_cnt [3];
   logic [2:0]          w_press;
   logic [C_PW-1:0]     r_presc;
   logic [C_BW-1:0]     r_bcd;
   logic [C_BW-1:0]     r_lap_latch;
   logic [C_BW-1:0]     w_bcd_next;
   logic [C_BW-1:0]     w_src;
   logic [7*DIGITS-1:0] w_seg;
   logic [7*DIGITS-1:0] r_hex;
   logic                r_ovf;
   logic                w_active;
   logic                w_tick;
   logic                w_wrap;
   logic                w_capture;
   logic                w_clear;

   function automatic logic [6:0] f_seg(input logic [3:0] v);
      case (v)
         4'd0:    f_seg = 7'h40;
         4'd1:    f_seg = 7'h79;
         4'd2:    f_seg = 7'h24;
         4'd3:    f_seg = 7'h30;
         4'd4:    f_seg = 7'h19;
         4'd5:    f_seg = 7'h12;
         4'd6:    f_seg = 7'h02;
         4'd7:    f_seg = 7'h78;
         4'd8:    f_seg = 7'h00;
         4'd9:    f_seg = 7'h10;
         default: f_seg = 7'h7F;
      endcase
   endfunction

   // Bit 0 start/stop, bit 1 lap, bit 2 clear; each gets a 2-flop sync and a stability counter.
   assign w_raw = {clear_i, lap_i, start_stop_i};

   always_ff @(posedge clk100_i) begin
      if (!rstn_i) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_level_d <= '0;
         for (int k = 0; k < 3; k++) r_deb_cnt[k] <= '0;
      end else begin
         r_sync1   <= w_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         for (int k = 0; k < 3; k++) begin
            if (r_sync2[k] != r_level[k]) begin
               if (r_deb_cnt[k] == C_DEB_LAST) begin
                  r_level[k]   <= r_sync2[k];
                  r_deb_cnt[k] <= '0;
               end else begin
                  r_deb_cnt[k] <= r_deb_cnt[k] + C_DW'(1);
               end
            end else begin
               r_deb_cnt[k] <= '0;
            end
         end
      end
   end

   assign w_press  = r_level & ~r_level_d;
   assign w_active = (r_state == S_RUN) || (r_state == S_LAP);
   assign w_tick   = w_active && (r_presc == C_TICK_LAST);

   always_ff @(posedge clk100_i) begin
      if (!rstn_i) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Checking start first, then lap, then clear drops lower-priority coincident presses.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_press[0]) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_press[0]) begin
               w_state_next = S_PAUSE;
            end else if (w_press[1]) begin
               w_state_next = S_LAP;
               w_capture    = 1'b1;
            end
         end
         S_LAP: begin
            if (w_press[0])      w_state_next = S_PAUSE;
            else if (w_press[1]) w_state_next = S_RUN;
         end
         S_PAUSE: begin
            if (w_press[0]) begin
               w_state_next = S_RUN;
            end else if (w_press[2]) begin
               w_state_next = S_IDLE;
               w_clear      = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Ripple increment; w_wrap survives only when every digit was 9.
   always_comb begin
      w_bcd_next = r_bcd;
      w_wrap     = w_tick;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_wrap) begin
            if (r_bcd[4*d +: 4] == 4'd9) begin
               w_bcd_next[4*d +: 4] = 4'd0;
            end else begin
               w_bcd_next[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
               w_wrap               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk100_i) begin
      if (!rstn_i) begin
         r_presc     <= '0;
         r_bcd       <= '0;
         r_lap_latch <= '0;
         r_ovf       <= 1'b0;
         r_hex       <= {DIGITS{7'h40}};
      end else begin
         if (w_clear) begin
            r_presc <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
         end else begin
            if (w_active) r_presc <= w_tick ? '0 : r_presc + C_PW'(1);
            if (w_tick)   r_bcd   <= w_bcd_next;
            if (w_wrap)   r_ovf   <= 1'b1;
         end
         if (w_capture) r_lap_latch <= r_bcd;
         r_hex <= w_seg;
      end
   end

   assign w_src = (r_state == S_LAP) ? r_lap_latch : r_bcd;

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign w_seg[7*d +: 7] = f_seg(w_src[4*d +: 4]);
   end

   assign hex_o      = r_hex;
   assign running_o  = w_active;
   assign lap_o      = (r_state == S_LAP);
   assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multi_stopwatch.sv
`default_nettype none
// tb_multi_stopwatch: directed, cycle-exact bench for multi_stopwatch (2 digits, tick every 4
// cycles, 2-cycle debounce). Rev 1.0
module tb_multi_stopwatch;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_stop = 1'b0;
   logic        lap = 1'b0;
   logic        clear = 1'b0;
   logic [13:0] hex;
   logic        running;
   logic        lap_flag;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   multi_stopwatch #(
      .DIGITS     (2),
      .TICK_DIV   (4),
      .DEB_CYCLES (2)
   ) dut (
      .clk100_i     (clk),
      .rstn_i       (rstn),
      .start_stop_i (start_stop),
      .lap_i        (lap),
      .clear_i      (clear),
      .hex_o        (hex),
      .running_o    (running),
      .lap_o        (lap_flag),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset
      cyc(5);
      rstn = 1'b1;
      cyc(1);
      check("reset_hex", hex, 14'h2040);
      check("reset_running", 14'(running), 14'd0);
      check("reset_lap", 14'(lap_flag), 14'd0);
      check("reset_overflow", 14'(overflow), 14'd0);

      // Start: press event reaches the state five edges after the button goes high
      start_stop = 1'b1;
      cyc(5);
      check("start_running", 14'(running), 14'd1);
      cyc(5);
      start_stop = 1'b0;
      cyc(36);
      check("count_10", hex, {7'h79, 7'h40});
      start_stop = 1'b1;
      cyc(5);
      start_stop = 1'b0;
      check("pause_running", 14'(running), 14'd0);
      check("pause_hex", hex, {7'h79, 7'h79});
      cyc(25);
      check("pause_hold_a", hex, {7'h79, 7'h79});
      cyc(25);
      check("pause_hold_b", hex, {7'h79, 7'h79});

      // Debounce: single-cycle pulse and 1/1 chatter must not register
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
      cyc(4);
      for (int i = 0; i < 8; i++) begin
         start_stop = (i % 2 == 0);
         cyc(1);
      end
      start_stop = 1'b0;
      cyc(8);
      check("glitch_running", 14'(running), 14'd0);
      check("glitch_hex", hex, {7'h79, 7'h79});

      // Lap: restart from zero, freeze at 05
      rstn = 1'b0;
      cyc(2);
      rstn = 1'b1;
      cyc(1);
      check("rereset_hex", hex, 14'h2040);
      start_stop = 1'b1;
      cyc(6);
      start_stop = 1'b0;
      check("lap_pre_running", 14'(running), 14'd1);
      cyc(16);
      lap = 1'b1;
      cyc(5);
      check("lap_enter", 14'(lap_flag), 14'd1);
      check("lap_running", 14'(running), 14'd1);
      cyc(1);
      lap = 1'b0;
      check("lap_frozen_a", hex, {7'h40, 7'h12});
      cyc(38);
      check("lap_frozen_b", hex, {7'h40, 7'h12});
      check("lap_still", 14'(lap_flag), 14'd1);
      lap = 1'b1;
      cyc(5);
      check("lap_exit", 14'(lap_flag), 14'd0);
      check("lap_exit_running", 14'(running), 14'd1);
      cyc(1);
      lap = 1'b0;
      check("lap_live_16", hex, {7'h79, 7'h02});

      // Wrap at 99 -> 00 with sticky overflow, then pause and clear
      cyc(331);
      check("count_99", hex, {7'h10, 7'h10});
      check("pre_wrap_ovf", 14'(overflow), 14'd0);
      cyc(4);
      check("wrap_hex", hex, {7'h40, 7'h40});
      check("wrap_ovf", 14'(overflow), 14'd1);
      start_stop = 1'b1;
      cyc(5);
      start_stop = 1'b0;
      check("wrap_pause_running", 14'(running), 14'd0);
      check("ovf_sticky", 14'(overflow), 14'd1);
      cyc(1);
      check("wrap_pause_hex", hex, {7'h40, 7'h79});
      cyc(4);
      clear = 1'b1;
      cyc(5);
      check("clear_running", 14'(running), 14'd0);
      check("clear_ovf", 14'(overflow), 14'd0);
      cyc(1);
      clear = 1'b0;
      check("clear_hex", hex, 14'h2040);

      // Clear during RUN is ignored
      cyc(6);
      start_stop = 1'b1;
      cyc(6);
      start_stop = 1'b0;
      check("run2_running", 14'(running), 14'd1);
      cyc(4);
      clear = 1'b1;
      cyc(6);
      clear = 1'b0;
      check("run_clear_running", 14'(running), 14'd1);
      check("run_clear_hex", hex, {7'h40, 7'h24});

      // Start and clear together in PAUSE: start wins, count kept
      cyc(1);
      start_stop = 1'b1;
      cyc(5);
      start_stop = 1'b0;
      check("pause2_running", 14'(running), 14'd0);
      cyc(1);
      check("pause2_hex", hex, {7'h40, 7'h19});
      cyc(6);
      start_stop = 1'b1;
      clear      = 1'b1;
      cyc(5);
      check("simul_running", 14'(running), 14'd1);
      check("simul_lap", 14'(lap_flag), 14'd0);
      cyc(1);
      start_stop = 1'b0;
      clear      = 1'b0;
      check("simul_hex", hex, {7'h40, 7'h19});

      // One-cycle reset mid-run
      rstn = 1'b0;
      cyc(1);
      rstn = 1'b1;
      check("midrst_hex", hex, 14'h2040);
      check("midrst_running", 14'(running), 14'd0);
      check("midrst_lap", 14'(lap_flag), 14'd0);
      check("midrst_ovf", 14'(overflow), 14'd0);
      cyc(3);
      check("post_rst_hex", hex, 14'h2040);
      check("post_rst_running", 14'(running), 14'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_stopwatch.md
Name: multi_stopwatch

Overview:
Parametrised stopwatch core that drives DIGITS seven-segment digits. It generalises the fixed 4-digit start/stop stopwatch with several additions: configurable tick rate and digit count, on-chip button synchronisation and debouncing, a lap (split) mode that freezes the display while counting continues, pause/clear, and an overflow flag. It sits between the board push-buttons and the 7-segment display driver on the 100 MHz board clock.

Parameters:
DIGITS, 4, number of decimal digits; legal range 1..8.
TICK_DIV, 1_000_000, clock cycles per count increment (100 Hz at 100 MHz); must be >= 2.
DEB_CYCLES, 100_000, consecutive stable cycles required to accept a button level; must be >= 1.

Ports:
clk100_i  input  1  system clock, 100 MHz.
rstn_i  input  1  reset; synchronous, active-low.
start_stop_i  input  1  raw start/stop button, active-high, asynchronous to clk.
lap_i  input  1  raw lap button, active-high, asynchronous.
clear_i  input  1  raw clear button, active-high, asynchronous.
hex_o  output  7*DIGITS  segment codes, digit k at [7k+6:7k], digit 0 is least significant; active-low, bit order gfedcba.
running_o  output  1  1 in RUN or LAP.
lap_o  output  1  1 in LAP (display frozen).
overflow_o  output  1  sticky wrap flag.

Behaviour:
- Reset (rstn_i=0 at a clock edge): state IDLE, BCD counter 0, prescaler 0, lap latch 0, debounced levels 0, overflow_o=0, running_o=0, lap_o=0, every hex_o digit = 7'h40.
- Button path, per input: 2-flop synchroniser, then a debouncer. The debounced level takes the synchronised value once that value has been stable and different from the current level for DEB_CYCLES consecutive cycles. Any glitch restarts the stability count.
- Press event: one-cycle pulse on the rising edge of a debounced level. A button held through reset release produces one press after sync plus DEB_CYCLES.
- Priority when events coincide in one cycle: start_stop > lap > clear. Lower-priority events in that cycle are dropped.
- FSM (state register updates on the cycle after the press pulse):
  - IDLE: start -> RUN. Lap and clear are ignored.
  - RUN: start -> PAUSE. Lap -> LAP, and the lap latch captures the counter value.
  - LAP: lap -> RUN, display returns to live. Start -> PAUSE, display returns to live.
  - PAUSE: start -> RUN. Clear -> IDLE, which zeroes the counter, prescaler and overflow_o. Lap is ignored.
  - Clear is ignored in RUN and LAP.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP.
  - Holds its value in PAUSE, so resume is seamless.
  - A tick occurs on the cycle where the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
- Counter:
  - DIGITS-digit BCD. Each digit counts 0..9 and carries into the next digit.
  - On a tick at all-9s, the counter wraps to all-0s and overflow_o is set. overflow_o stays set until clear or reset.
- Display source: lap latch in LAP, live counter otherwise.
- hex_o is registered: it reflects the source value one cycle after the value changes.
- Segment encoding, digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). BCD values above 9 cannot occur.
- running_o and lap_o are decoded from the registered state.

Test Plan:
Benches use DIGITS=2, TICK_DIV=4, DEB_CYCLES=2.
1. Reset: hold rstn_i=0 for 5 cycles, then release -> hex_o=14'h2040 ({7'h40,7'h40}), running_o=0, lap_o=0, overflow_o=0.
2. Start and count: press start for 10 cycles. Once running_o=1, wait 40 cycles -> counter reads 10, hex_o={7'h79,7'h40}. A second start press -> running_o=0 and hex_o holds steady for 50 cycles.
3. Debounce: drive a 1-cycle start_stop_i pulse, and a 1-high/1-low chatter pattern for 8 cycles -> no press event, state unchanged.
4. Lap: in RUN at count 05, press lap -> lap_o=1 and hex_o frozen at {7'h40,7'h12} for 40 cycles while the counter advances to 15. Press lap again -> lap_o=0 and hex_o shows the live count.
5. Wrap and clear: run from 00 for 100 ticks -> display 00, overflow_o=1. Pause, then press clear -> IDLE, overflow_o=0, display 00. Clear pressed in RUN -> ignored.
6. Simultaneous and reset: in PAUSE, press start and clear together -> RUN, count unchanged. Assert rstn_i=0 mid-RUN for 1 cycle -> all reset values one cycle later.
